mem_bus_bridge: RTL

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_bridge.sv
// Bridges RV32I load/store requests onto a single-pulse memory bus with one outstanding transaction.
// Optional WAIT timeout with a DRAIN state is compiled in when MEM_BUS_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a new request
// S_ISSUE | one-cycle bus start pulse (skipped for an illegal funct3)
// S_WAIT  | waiting for the memory completion pulse
// S_RESP  | one-cycle response pulse to the requester
// S_DRAIN | after a timeout, swallow the late completion pulse (optional)
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
`ifdef MEM_BUS_TIMEOUT_EN
        S_DRAIN,
`endif
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        write_q;
    logic        legal_q;
    logic [2:0]  bhw_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        req_legal;
`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
`endif

    assign accept = (state == S_IDLE) && i_req_valid;

    always_comb begin
        req_legal = 1'b0;
        if (i_req_write) begin
            req_legal = (i_req_funct3 == 3'd0) || (i_req_funct3 == 3'd1) || (i_req_funct3 == 3'd2);
        end else begin
            case (i_req_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: req_legal = 1'b1;
                default:                      req_legal = 1'b0;
            endcase
        end
    end

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {{24{d[7]}}, d[7:0]};
            3'd1:    return {{16{d[15]}}, d[15:0]};
            3'd4:    return {24'd0, d[7:0]};
            3'd5:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_req_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = legal_q ? S_WAIT : S_RESP;
            S_WAIT: begin
                if (i_bus_DV) state_nxt = S_RESP;
`ifdef MEM_BUS_TIMEOUT_EN
                else if (wait_cnt == '0) state_nxt = S_RESP;
`endif
            end
`ifdef MEM_BUS_TIMEOUT_EN
            S_RESP:  state_nxt = timeout_q ? S_DRAIN : S_IDLE;
            S_DRAIN: if (i_bus_DV) state_nxt = S_IDLE;
`else
            S_RESP:  state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus fields are registered at acceptance so they stay stable through ISSUE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            write_q   <= 1'b0;
            legal_q   <= 1'b0;
            bhw_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= i_req_addr;
                f3_q    <= i_req_funct3;
                write_q <= i_req_write;
                legal_q <= req_legal;
                rdata_q <= '0;
                err_q   <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
                case (i_req_funct3[1:0])
                    2'd0:    bhw_q <= req_legal ? 3'd1 : 3'd0;
                    2'd1:    bhw_q <= req_legal ? 3'd2 : 3'd0;
                    2'd2:    bhw_q <= req_legal ? 3'd4 : 3'd0;
                    default: bhw_q <= 3'd0;
                endcase
                if (!i_req_write || !req_legal) wdata_q <= '0;
                else if (i_req_funct3 == 3'd0)  wdata_q <= {i_req_wdata[7:0], 24'd0};
                else if (i_req_funct3 == 3'd1)  wdata_q <= {i_req_wdata[15:0], 16'd0};
                else                            wdata_q <= i_req_wdata;
            end
            if (state == S_ISSUE) begin
                if (!legal_q) err_q <= 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
                wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            if (state == S_WAIT) begin
                if (i_bus_DV) begin
                    rdata_q <= write_q ? 32'd0 : extend_load(f3_q, i_bus_data);
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (wait_cnt == '0) begin
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
`endif
            end
        end
    end

    assign o_req_ready     = (state == S_IDLE);
    assign o_bus_DV        = (state == S_ISSUE) && legal_q;
    assign o_rsp_valid     = (state == S_RESP);
    assign o_rsp_rdata     = rdata_q;
    assign o_rsp_err       = err_q;
    assign o_bus_data      = wdata_q;
    assign o_bus_address   = addr_q;
    assign o_bhw           = bhw_q;
    assign o_write_notread = write_q;

endmodule
